// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, the master FSM state type and
// the width helper for the handshake timeout counter.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_DATA,
    ST_RSP
  } axi_mst_state_e;

  // A disabled timeout (0) still needs a one-bit counter to keep widths legal.
  function automatic int timeout_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one command in, one single-beat AXI transaction out,
// one response back. Only one transaction is ever outstanding.
module axi4_lite_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  timeout,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp
);

  localparam int TIMEOUT_W = timeout_w(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = TIMEOUT_W'(TIMEOUT);
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

  axi_mst_state_e        state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [TIMEOUT_W-1:0]  cnt_q;
  logic                  timeout_q;
  logic                  waiting;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          write_d = cmd_write;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        // AW and W retire independently; move on once neither is pending.
        if (m_awready) awvalid_d = 1'b0;
        if (m_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (m_bvalid) begin
          resp_d   = m_bresp;
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = ST_RSP;
        end
      end
      ST_RD_REQ: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (m_rvalid) begin
          rdata_d  = m_rdata;
          resp_d   = m_rresp;
          rready_d = 1'b0;
          state_d  = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign waiting = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);

  // Saturating watchdog; it only flags a stall and never aborts the transfer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (waiting && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
      if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) timeout_q <= 1'b1;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign timeout   = timeout_q;

  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_awprot  = 3'b000;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = bready_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = 3'b000;
  assign m_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Scoreboard bench for axi4_lite_master against a small register-slave peer
// (64 bytes mapped at 0x00, SLVERR/0xDEADBEEF above) and a word-level model.
module tb_axi4_lite_master;
  import axi_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_bvalid = 1'b0, m_bready;
  logic [1:0]  m_bresp = '0;
  logic        m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;

  int   tests = 0;
  int   fails = 0;
  rsp_t expQ[$];
  logic [31:0] refMem [16];
  logic [7:0]  slaveBytes [64];
  int   forceAw = -1;
  int   forceW = -1;
  bit   holdB = 1'b0;
  bit   holdAr = 1'b0;
  int   rspStall = 0;

  axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .timeout(timeout),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outcome derived from the address map and byte-strobe rules.
  function automatic rsp_t refModel(input bit wr, input logic [31:0] a,
                                    input logic [31:0] d, input logic [3:0] s);
    rsp_t r;
    r.wr = wr;
    if (a < 32'h40) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) refMem[a[5:2]][8*b +: 8] = d[8*b +: 8];
        r.rdata = '0;
      end else begin
        r.rdata = refMem[a[5:2]];
      end
      r.resp = RESP_OKAY;
    end else begin
      r.rdata = wr ? 32'h0 : 32'hDEAD_BEEF;
      r.resp  = RESP_SLVERR;
    end
    return r;
  endfunction

  task automatic applyStimulus(input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    for (int n = 0; !cmd_ready; n++) begin
      if (n > 500) begin
        checkOutput("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b0;
        return;
      end
      @(negedge aclk);
    end
    expQ.push_back(refModel(wr, a, d, s));
    @(negedge aclk);
    cmd_valid = 1'b0;
    if (wr) begin
      checkOutput("aw_w_valid_latency", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
      checkOutput("awaddr", 64'(m_awaddr), 64'(a));
    end else begin
      checkOutput("arvalid_latency", 64'(m_arvalid), 64'(1));
      checkOutput("araddr", 64'(m_araddr), 64'(a));
    end
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 1000; n++) begin
      if (expQ.size() == 0 && !rsp_valid && cmd_ready) return;
      @(negedge aclk);
    end
    checkOutput("idle_timeout_pending", 64'(expQ.size()), 64'(0));
  endtask

  task automatic slaveWrite();
    int da, dw, db, idx;
    bit awGot, wGot;
    logic [31:0] a, d;
    logic [3:0] s;
    logic [1:0] r;
    da = (forceAw >= 0) ? forceAw : int'($urandom_range(0, 3));
    dw = (forceW >= 0) ? forceW : int'($urandom_range(0, 3));
    forceAw = -1;
    forceW = -1;
    awGot = 1'b0;
    wGot = 1'b0;
    a = '0; d = '0; s = '0;
    for (int t = 0; t < 200 && !(awGot && wGot); t++) begin
      if (areset) begin m_awready = 1'b0; m_wready = 1'b0; return; end
      m_awready = !awGot && (t >= da);
      m_wready  = !wGot && (t >= dw);
      if (m_awready && m_awvalid) begin awGot = 1'b1; a = m_awaddr; end
      if (m_wready && m_wvalid) begin wGot = 1'b1; d = m_wdata; s = m_wstrb; end
      @(negedge aclk);
    end
    m_awready = 1'b0;
    m_wready = 1'b0;
    if (!(awGot && wGot)) return;
    if (a < 32'h40) begin
      idx = int'(a[5:2]) * 4;
      for (int b = 0; b < 4; b++) if (s[b]) slaveBytes[idx + b] = d[8*b +: 8];
      r = RESP_OKAY;
    end else begin
      r = RESP_SLVERR;
    end
    db = int'($urandom_range(0, 3));
    for (int i = 0; i < db || holdB; i++) begin
      if (areset || i > 500) return;
      @(negedge aclk);
    end
    m_bvalid = 1'b1;
    m_bresp  = r;
    for (int t = 0; t < 500; t++) begin
      if (areset) break;
      if (m_bready) begin @(negedge aclk); break; end
      @(negedge aclk);
    end
    m_bvalid = 1'b0;
  endtask

  task automatic slaveRead();
    int da, dr, idx;
    bit got;
    logic [31:0] a;
    da = int'($urandom_range(0, 3));
    got = 1'b0;
    a = '0;
    for (int t = 0; t < 1000 && !got; t++) begin
      if (areset) begin m_arready = 1'b0; return; end
      m_arready = (t >= da) && !holdAr;
      if (m_arready && m_arvalid) begin got = 1'b1; a = m_araddr; end
      @(negedge aclk);
    end
    m_arready = 1'b0;
    if (!got) return;
    dr = int'($urandom_range(0, 3));
    for (int i = 0; i < dr; i++) begin
      if (areset) return;
      @(negedge aclk);
    end
    if (a < 32'h40) begin
      idx = int'(a[5:2]) * 4;
      m_rdata = {slaveBytes[idx + 3], slaveBytes[idx + 2], slaveBytes[idx + 1], slaveBytes[idx]};
      m_rresp = RESP_OKAY;
    end else begin
      m_rdata = 32'hDEAD_BEEF;
      m_rresp = RESP_SLVERR;
    end
    m_rvalid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      if (areset) break;
      if (m_rready) begin @(negedge aclk); break; end
      @(negedge aclk);
    end
    m_rvalid = 1'b0;
  endtask

  // Peer slave: reacts on the falling edge so the DUT samples settled values.
  initial begin
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (m_awvalid || m_wvalid) slaveWrite();
        else if (m_arvalid) slaveRead();
      end
    end
  end

  // Response monitor: owns rsp_ready and pops the scoreboard on each handshake.
  initial begin
    bit inRsp;
    int stallLeft;
    rsp_t e;
    inRsp = 1'b0;
    stallLeft = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        rsp_ready = 1'b0;
        inRsp = 1'b0;
      end else begin
        if (rsp_valid && !inRsp) begin
          inRsp = 1'b1;
          stallLeft = (rspStall > 0) ? rspStall : int'($urandom_range(0, 2));
          rspStall = 0;
        end
        if (inRsp) begin
          checkOutput("cmd_ready_low_in_rsp", 64'(cmd_ready), 64'(0));
          if (stallLeft > 0) begin
            rsp_ready = 1'b0;
            stallLeft--;
          end else begin
            rsp_ready = 1'b1;
            inRsp = 1'b0;
            if (expQ.size() == 0) begin
              checkOutput("unexpected_rsp_queue_empty", 64'(rsp_valid), 64'(0));
            end else begin
              e = expQ.pop_front();
              checkOutput("rsp_write", 64'(rsp_write), 64'(e.wr));
              checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
              checkOutput("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            end
          end
        end else begin
          rsp_ready = 1'b0;
        end
      end
    end
  end

  // Protocol watcher: a valid without a handshake must persist with stable payload.
  initial begin
    bit pRst, pAw, pAwF, pW, pWF, pAr, pArF, pRsp, pRspF, pRw;
    logic [31:0] pAwA, pWd, pArA, pRd;
    logic [3:0] pWs;
    logic [1:0] pRr;
    pRst = 1'b1;
    {pAw, pAwF, pW, pWF, pAr, pArF, pRsp, pRspF, pRw} = '0;
    pAwA = '0; pWd = '0; pArA = '0; pRd = '0; pWs = '0; pRr = '0;
    forever begin
      @(negedge aclk);
      #1;
      if (!pRst) begin
        if (pAw && !pAwF) begin
          checkOutput("awvalid_held", 64'(m_awvalid), 64'(1));
          checkOutput("awaddr_stable", 64'(m_awaddr), 64'(pAwA));
        end
        if (pW && !pWF) begin
          checkOutput("wvalid_held", 64'(m_wvalid), 64'(1));
          checkOutput("wdata_wstrb_stable", 64'({m_wstrb, m_wdata}), 64'({pWs, pWd}));
        end
        if (pAr && !pArF) begin
          checkOutput("arvalid_held", 64'(m_arvalid), 64'(1));
          checkOutput("araddr_stable", 64'(m_araddr), 64'(pArA));
        end
        if (pRsp && !pRspF) begin
          checkOutput("rsp_valid_held", 64'(rsp_valid), 64'(1));
          checkOutput("rsp_stable", 64'({rsp_write, rsp_resp, rsp_rdata}), 64'({pRw, pRr, pRd}));
        end
      end
      pRst  = areset;
      pAw   = m_awvalid; pAwF = m_awvalid && m_awready; pAwA = m_awaddr;
      pW    = m_wvalid;  pWF  = m_wvalid && m_wready;   pWd = m_wdata; pWs = m_wstrb;
      pAr   = m_arvalid; pArF = m_arvalid && m_arready; pArA = m_araddr;
      pRsp  = rsp_valid; pRspF = rsp_valid && rsp_ready;
      pRw   = rsp_write; pRr = rsp_resp; pRd = rsp_rdata;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete, got running expected done");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    for (int i = 0; i < 16; i++) refMem[i] = '0;
    for (int i = 0; i < 64; i++) slaveBytes[i] = '0;
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("reset_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}), 64'(0));
    checkOutput("reset_timeout", 64'(timeout), 64'(0));
    checkOutput("reset_regs", 64'({m_awaddr, m_wdata} | 64'({rsp_rdata, rsp_resp})), 64'(0));
    areset = 1'b0;
    @(negedge aclk);

    $display("[TB] write then read");
    applyStimulus(1'b1, 32'h18, 32'hA5A5_5A5A, 4'hF);
    applyStimulus(1'b0, 32'h18, 32'h0, 4'h0);
    $display("[TB] byte strobes");
    applyStimulus(1'b1, 32'h18, 32'h0, 4'hF);
    applyStimulus(1'b1, 32'h18, 32'hFFFF_FFFF, 4'h2);
    applyStimulus(1'b0, 32'h18, 32'h0, 4'h0);
    $display("[TB] out of range");
    applyStimulus(1'b1, 32'h40, 32'h1234_5678, 4'hF);
    applyStimulus(1'b0, 32'h40, 32'h0, 4'h0);
    waitIdle();

    $display("[TB] backpressure");
    forceAw = 3;
    forceW = 0;
    rspStall = 5;
    applyStimulus(1'b1, 32'h18, 32'h0BAD_F00D, 4'hF);
    @(negedge aclk);
    checkOutput("wvalid_dropped", 64'(m_wvalid), 64'(0));
    checkOutput("awvalid_waiting", 64'(m_awvalid), 64'(1));
    checkOutput("awaddr_waiting", 64'(m_awaddr), 64'(32'h18));
    waitIdle();

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19) * 4), $urandom, 4'($urandom_range(0, 15)));
    end
    waitIdle();

    $display("[TB] reset mid-transaction");
    holdB = 1'b1;
    applyStimulus(1'b1, 32'h10, 32'hCAFE_0123, 4'hF);
    for (int n = 0; n < 50 && !m_bready; n++) @(negedge aclk);
    checkOutput("bready_reached", 64'(m_bready), 64'(1));
    areset = 1'b1;
    @(negedge aclk);
    checkOutput("abort_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid}), 64'(0));
    checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge aclk);
    areset = 1'b0;
    holdB = 1'b0;
    expQ.delete();
    @(negedge aclk);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
    waitIdle();

    $display("[TB] timeout");
    holdAr = 1'b1;
    applyStimulus(1'b0, 32'h18, 32'h0, 4'h0);
    repeat (TMO - 1) @(negedge aclk);
    checkOutput("timeout_not_yet", 64'(timeout), 64'(0));
    @(negedge aclk);
    checkOutput("timeout_set", 64'(timeout), 64'(1));
    checkOutput("arvalid_still_high", 64'(m_arvalid), 64'(1));
    holdAr = 1'b0;
    waitIdle();
    checkOutput("timeout_sticky", 64'(timeout), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
